risc5_sram_ctrl: RTL and testbench

Bus responder for the RISC5 CPU memory port. It serves every CPU cycle's access (instruction fetch or data load/store) from an external asynchronous 16-bit SRAM as one or two halfword transactions. It holds `memwait` high until the result is valid, and returns read data on both `codebus` and `inbus`. It sits between the CPU and the board SRAM pins; the tristate pad lives in the top level.

---
 rtl/risc5_sram_ctrl.sv | 123 ++++++++++++
 tb/tb_risc5_sram_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc5_sram_ctrl.sv
// RISC5 memory-port responder: serves each CPU access from a 16-bit async SRAM
// as one (byte) or two (word) halfword phases, holding memwait until DONE.
module risc5_sram_ctrl #(
  parameter int AW = 20,
  parameter int WS = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [23:0]   adr,
  input  logic          rd,
  input  logic          wr,
  input  logic          ben,
  input  logic [31:0]   outbus,
  output logic [31:0]   inbus,
  output logic [31:0]   codebus,
  output logic          memwait,
  output logic [AW-1:0] sram_a,
  input  logic [15:0]   sram_dq_in,
  output logic [15:0]   sram_dq_out,
  output logic          sram_dq_oe,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic          sram_ub_n,
  output logic          sram_lb_n
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [4:0] LAST = 5'(WS + 1);

  state_t        state, state_nxt;
  logic [4:0]    cnt;
  logic [AW:0]   adr_p0;
  logic          wr_p0;
  logic          byte_p0;
  logic [31:0]   wdata_p0;
  logic [31:0]   data_p1;
  logic          phase;
  logic          half;
  logic          last;
  logic          unused_adr;

  assign unused_adr = ^adr[23:AW+1];

  assign phase = (state == LO) || (state == HI);
  assign half  = (state == HI);
  assign last  = phase && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // phase counter: restarts on every phase entry, so it never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= 5'd0;
    else if (!phase || last) cnt <= 5'd0;
    else                    cnt <= cnt + 5'd1;
  end

  // stage 0: request capture in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_p0   <= '0;
      wr_p0    <= 1'b0;
      byte_p0  <= 1'b0;
      wdata_p0 <= '0;
    end else if (state == IDLE) begin
      adr_p0   <= adr[AW:0];
      wr_p0    <= wr;
      byte_p0  <= ben && (rd || wr);
      wdata_p0 <= outbus;
    end
  end

  // stage 1: read data capture at the end of the last strobe cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p1 <= '0;
    end else if (last && !wr_p0) begin
      if (byte_p0)   data_p1 <= half ? {sram_dq_in, 16'h0000} : {16'h0000, sram_dq_in};
      else if (half) data_p1[31:16] <= sram_dq_in;
      else           data_p1[15:0]  <= sram_dq_in;
    end
  end

  always_comb begin
    state_nxt  = state;
    memwait    = 1'b1;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    sram_ub_n  = 1'b1;
    sram_lb_n  = 1'b1;
    case (state)
      IDLE: state_nxt = (ben && (rd || wr) && adr[1]) ? HI : LO;
      LO:   if (last) state_nxt = byte_p0 ? DONE : HI;
      HI:   if (last) state_nxt = DONE;
      DONE: begin
        memwait   = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // cycle 0 of a phase is address setup; strobes assert from cycle 1
    if (phase) begin
      sram_ce_n  = 1'b0;
      sram_dq_oe = wr_p0;
      sram_oe_n  = wr_p0 || (cnt == 5'd0);
      sram_we_n  = !wr_p0 || (cnt == 5'd0);
      sram_ub_n  = byte_p0 & ~adr_p0[0];
      sram_lb_n  = byte_p0 & adr_p0[0];
    end
  end

  assign sram_a      = {adr_p0[AW:2], half};
  assign sram_dq_out = half ? wdata_p0[31:16] : wdata_p0[15:0];
  assign inbus       = data_p1;
  assign codebus     = data_p1;

endmodule

// File: tb/tb_risc5_sram_ctrl.sv
// Bench for risc5_sram_ctrl: per-cycle expected pin behaviour built from the
// access rules, a behavioural SRAM per DUT, and literal data/latency checks.
module tb_risc5_sram_ctrl;

  localparam int WS1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] adr = '0;
  logic        rd = 1'b0, wr = 1'b0, ben = 1'b0;
  logic [31:0] outbus = '0;
  logic [31:0] inbus, codebus;
  logic        memwait;
  logic [19:0] sram_a;
  logic [15:0] dq_in, dq_out;
  logic        dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;

  logic [23:0] adr_b = 24'h000200;
  logic [31:0] inbus0, codebus0, inbus3, codebus3;
  logic        memwait0, memwait3;
  logic [19:0] a0, a3;
  logic [15:0] din0, din3, dout0, dout3;
  logic        doe0, doe3, ce0, ce3, oe0, oe3, we0, we3, ub0, ub3, lb0, lb3;

  logic [15:0] mem1 [0:1023];
  logic [15:0] memr [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic [31:0] mdata = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [6:0]  ctl;   // {memwait, ce_n, oe_n, we_n, dq_oe, ub_n, lb_n}
    logic [19:0] a;
    logic        chk_a;
    logic [15:0] d;
    logic        chk_d;
    logic [31:0] din;
    logic        chk_in;
  } rec_t;

  rec_t exp_q[$];

  risc5_sram_ctrl #(.AW(20), .WS(WS1)) u1 (
    .clk(clk), .rst(rst), .adr(adr), .rd(rd), .wr(wr), .ben(ben), .outbus(outbus),
    .inbus(inbus), .codebus(codebus), .memwait(memwait), .sram_a(sram_a),
    .sram_dq_in(dq_in), .sram_dq_out(dq_out), .sram_dq_oe(dq_oe), .sram_ce_n(ce_n),
    .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n)
  );

  risc5_sram_ctrl #(.AW(20), .WS(0)) u0 (
    .clk(clk), .rst(rst), .adr(adr_b), .rd(1'b0), .wr(1'b0), .ben(1'b0), .outbus(32'h0),
    .inbus(inbus0), .codebus(codebus0), .memwait(memwait0), .sram_a(a0),
    .sram_dq_in(din0), .sram_dq_out(dout0), .sram_dq_oe(doe0), .sram_ce_n(ce0),
    .sram_oe_n(oe0), .sram_we_n(we0), .sram_ub_n(ub0), .sram_lb_n(lb0)
  );

  risc5_sram_ctrl #(.AW(20), .WS(3)) u3 (
    .clk(clk), .rst(rst), .adr(adr_b), .rd(1'b0), .wr(1'b0), .ben(1'b0), .outbus(32'h0),
    .inbus(inbus3), .codebus(codebus3), .memwait(memwait3), .sram_a(a3),
    .sram_dq_in(din3), .sram_dq_out(dout3), .sram_dq_oe(doe3), .sram_ce_n(ce3),
    .sram_oe_n(oe3), .sram_we_n(we3), .sram_ub_n(ub3), .sram_lb_n(lb3)
  );

  always #5 clk = ~clk;

  assign dq_in = mem1[sram_a[9:0]];
  assign din0  = memr[a0[9:0]];
  assign din3  = memr[a3[9:0]];

  // behavioural SRAM pads; contents reload while reset is held
  always @(posedge clk) begin
    if (rst) begin
      mem1[10'h100] <= 16'h1234; mem1[10'h101] <= 16'hABCD;
      mem1[10'h008] <= 16'h0000; mem1[10'h009] <= 16'h5AA5; mem1[10'h00A] <= 16'h0000;
      mem1[10'h018] <= 16'h0000; mem1[10'h019] <= 16'h0000;
      memr[10'h100] <= 16'h1234; memr[10'h101] <= 16'hABCD;
      memr[10'h102] <= 16'h5678; memr[10'h103] <= 16'h9ABC;
    end else if (!ce_n && !we_n) begin
      if (!lb_n) mem1[sram_a[9:0]][7:0]  <= dq_out[7:0];
      if (!ub_n) mem1[sram_a[9:0]][15:8] <= dq_out[15:8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin : compare
    rec_t r;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      cyc++;
      chk($sformatf("pins c%0d", cyc), {25'b0, memwait, ce_n, oe_n, we_n, dq_oe, ub_n, lb_n},
          {25'b0, r.ctl});
      if (r.chk_a)  chk($sformatf("sram_a c%0d", cyc), {12'b0, sram_a}, {12'b0, r.a});
      if (r.chk_d)  chk($sformatf("dq_out c%0d", cyc), {16'b0, dq_out}, {16'b0, r.d});
      if (r.chk_in) begin
        chk($sformatf("inbus c%0d", cyc), inbus, r.din);
        chk($sformatf("codebus c%0d", cyc), codebus, r.din);
      end
    end
  end

  // one access on u1; call just after a clock edge that starts an IDLE cycle
  task automatic acc(input logic w, input logic r, input logic b,
                     input logic [23:0] a, input logic [31:0] ob);
    rec_t rc;
    int n;
    int nh;
    logic byte_acc;
    logic hb;
    logic [9:0] idx;
    logic [15:0] d;
    adr = a; wr = w; rd = r; ben = b; outbus = ob;
    byte_acc = b && (r || w);
    nh = byte_acc ? 1 : 2;
    rc.ctl = 7'b1111011; rc.a = '0; rc.chk_a = 1'b0; rc.d = '0; rc.chk_d = 1'b0;
    rc.din = '0; rc.chk_in = 1'b0;
    exp_q.push_back(rc);
    n = 1;
    for (int k = 0; k < nh; k++) begin
      hb  = byte_acc ? a[1] : k[0];
      d   = hb ? ob[31:16] : ob[15:0];
      idx = {a[10:2], hb};
      for (int c = 0; c <= WS1 + 1; c++) begin
        rc.ctl = {1'b1, 1'b0, (c == 0) || w, (c == 0) || !w, w,
                  byte_acc ? ~a[0] : 1'b0, byte_acc ? a[0] : 1'b0};
        rc.a = {a[20:2], hb}; rc.chk_a = 1'b1;
        rc.d = d; rc.chk_d = w;
        exp_q.push_back(rc);
        n++;
      end
      if (w) begin
        if (!byte_acc)  ref_mem[idx] = d;
        else if (a[0])  ref_mem[idx][15:8] = d[15:8];
        else            ref_mem[idx][7:0] = d[7:0];
      end else begin
        if (byte_acc)   mdata = hb ? {ref_mem[idx], 16'h0000} : {16'h0000, ref_mem[idx]};
        else if (hb)    mdata[31:16] = ref_mem[idx];
        else            mdata[15:0] = ref_mem[idx];
      end
    end
    rc.ctl = 7'b0111011; rc.chk_a = 1'b0; rc.chk_d = 1'b0; rc.din = mdata; rc.chk_in = 1'b1;
    exp_q.push_back(rc);
    n++;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ref_mem[10'h100] = 16'h1234; ref_mem[10'h101] = 16'hABCD;
    ref_mem[10'h008] = 16'h0000; ref_mem[10'h009] = 16'h5AA5; ref_mem[10'h00A] = 16'h0000;
    ref_mem[10'h018] = 16'h0000; ref_mem[10'h019] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst memwait", {31'b0, memwait}, 32'd1);
    chk("rst strobes", {27'b0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
    chk("rst dq_oe", {31'b0, dq_oe}, 32'd0);
    chk("rst sram_a", {12'b0, sram_a}, 32'd0);
    chk("rst dq_out", {16'b0, dq_out}, 32'd0);
    chk("rst inbus", inbus, 32'd0);
    chk("rst ws3 memwait", {31'b0, memwait3}, 32'd1);
    rst = 1'b0;

    fork
      begin : seq1
        acc(1'b0, 1'b0, 1'b0, 24'h000200, 32'h0);
        chk("fetch word", inbus, 32'hABCD1234);
        acc(1'b0, 1'b1, 1'b1, 24'h000012, 32'h0);
        chk("byte load", inbus, 32'h5AA50000);
        acc(1'b1, 1'b0, 1'b0, 24'h000010, 32'hDEADBEEF);
        chk("store lo", {16'b0, mem1[10'h008]}, 32'h0000BEEF);
        chk("store hi", {16'b0, mem1[10'h009]}, 32'h0000DEAD);
        chk("inbus kept", inbus, 32'h5AA50000);
        acc(1'b1, 1'b0, 1'b1, 24'h000013, 32'h77777777);
        chk("byte store ub", {16'b0, mem1[10'h009]}, 32'h000077AD);
        acc(1'b1, 1'b0, 1'b1, 24'h000014, 32'h55555555);
        chk("byte store lb", {16'b0, mem1[10'h00A]}, 32'h00000055);
        acc(1'b1, 1'b1, 1'b0, 24'h000030, 32'h01020304);
        chk("wr wins lo", {16'b0, mem1[10'h018]}, 32'h00000304);
        chk("wr wins hi", {16'b0, mem1[10'h019]}, 32'h00000102);
        acc(1'b0, 1'b1, 1'b0, 24'h000010, 32'h0);
        chk("word load", inbus, 32'h77ADBEEF);
        acc(1'b0, 1'b1, 1'b1, 24'h000014, 32'h0);
        chk("byte load lo", inbus, 32'h00000055);
        acc(1'b0, 1'b0, 1'b0, 24'h000030, 32'h0);
        chk("fetch stored", codebus, 32'h01020304);
      end
      begin : seq0
        int n0;
        n0 = 0;
        while (1) begin
          @(negedge clk);
          n0++;
          if (!memwait0 || n0 >= 40) break;
        end
        chk("ws0 latency", n0, 32'd6);
        chk("ws0 fetch", codebus0, 32'hABCD1234);
        @(posedge clk);
        #1 adr_b = 24'h000204;
        n0 = 0;
        while (1) begin
          @(negedge clk);
          n0++;
          if (!memwait0 || n0 >= 40) break;
        end
        chk("ws0 b2b latency", n0, 32'd6);
        chk("ws0 b2b fetch", codebus0, 32'h9ABC5678);
      end
      begin : seq3
        int n3;
        n3 = 0;
        while (1) begin
          @(negedge clk);
          n3++;
          if (!memwait3 || n3 >= 40) break;
        end
        chk("ws3 latency", n3, 32'd12);
        chk("ws3 fetch", codebus3, 32'hABCD1234);
      end
    join

    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wr = 1'b1; rd = 1'b0; ben = 1'b0; adr = 24'h000020; outbus = 32'h11112222;
    repeat (5) @(posedge clk);
    #2;
    chk("hi write we_n", {31'b0, we_n}, 32'd0);
    chk("hi write dq_oe", {31'b0, dq_oe}, 32'd1);
    chk("hi write sram_a", {12'b0, sram_a}, 32'h00011);
    chk("hi write dq_out", {16'b0, dq_out}, 32'h00001111);
    rst = 1'b1;
    #1;
    chk("async rst we_n", {31'b0, we_n}, 32'd1);
    chk("async rst dq_oe", {31'b0, dq_oe}, 32'd0);
    chk("async rst ce_n", {31'b0, ce_n}, 32'd1);
    chk("async rst memwait", {31'b0, memwait}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("post rst inbus", inbus, 32'd0);
    chk("post rst sram_a", {12'b0, sram_a}, 32'd0);
    chk("post rst dq_out", {16'b0, dq_out}, 32'd0);
    mdata = '0;
    acc(1'b0, 1'b0, 1'b0, 24'h000200, 32'h0);
    chk("post rst fetch", codebus, 32'hABCD1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
